apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB slave register memory that sits directly downstream of the team's APB master and completes its SETUP/ACCESS transfers. It holds MEM_DEPTH words of DATA_WIDTH bits, supports byte-strobed writes, inserts a fixed number of wait states, and flags out-of-range or misaligned accesses with PSLVERR. It is the single slave (NO_SLAVES = 1) on the bus and the DUT-side target for the master's read/write/toggle/random test sequences.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width; a multiple of 8.
- ADDR_WIDTH, 32, PADDR width.
- MEM_DEPTH, 16, number of words; a power of two, ≥ 2.
- WAIT_CYCLES, 0, wait states inserted per transfer; range 0–15.
- PCLK  in  1  single clock; all logic on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY = 1.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY = 1.

## Operation
- One-hot FSM: IDLE = 3'b001, SETUP = 3'b010, ACCESS = 3'b100.
- IDLE: at the edge, if PSEL=1 and PENABLE=0:
  - latch PADDR, PWRITE, PWDATA and PSTRB;
  - load the 4-bit wait counter with WAIT_CYCLES;
  - go to SETUP.
- Otherwise IDLE stays in IDLE. PENABLE=1 without a preceding setup is ignored, with no response.
- SETUP and ACCESS, when PSEL=1 and PENABLE=1:
  - counter = 0: the transfer completes this cycle, and the next state is IDLE;
  - counter ≠ 0: decrement the counter, and the next state is ACCESS.
- SETUP and ACCESS, when PSEL=0 or PENABLE=0: abort the transfer and go to IDLE. No memory write occurs. That cycle is not re-sampled as a new setup.
- All decode uses the latched fields. Bus changes after setup are ignored.
- Error condition, from the latched address:
  - PADDR[1:0] ≠ 0, or
  - word index PADDR[ADDR_WIDTH-1:2] ≥ MEM_DEPTH.
- Completing write, no error: for each i with PSTRB[i]=1, byte i of mem[index] takes PWDATA byte i at the completion edge. An all-zero PSTRB is a legal no-op with PSLVERR=0.
- Completing write, error: memory is unchanged and PSLVERR=1.
- Completing read: PRDATA = mem[index], or 0 on error with PSLVERR=1. PSTRB is ignored.
- PREADY = PSEL & PENABLE & (state ∈ {SETUP, ACCESS}) & (counter == 0).
  - PRDATA is 0 and PSLVERR is 0 whenever PREADY = 0.
  - PREADY, PRDATA and PSLVERR are combinational from registered state, counter, latched fields and memory, gated by PSEL/PENABLE only.
- Reset (PRESET=1 at an edge):
  - state → IDLE, counter → 0, latched fields → 0;
  - all memory words → 0.
  - Reset has priority over any transfer. A write completing in the same cycle as reset is discarded.

## Timing
- T0: setup cycle (PSEL=1, PENABLE=0), sampled at the end of T0.
- T1: first access cycle. Completion (PREADY=1) occurs in cycle T1 + WAIT_CYCLES.
  - WAIT_CYCLES=0 gives a 2-cycle transfer with no wait states.
- Write data reaches memory at the rising edge ending the completion cycle.
- A read in the next transfer returns the new value.
- Back-to-back transfers: the FSM returns to IDLE after completion, so a new setup in the cycle immediately after completion is accepted, with no dead cycle.
- Reset mid-transfer: in the cycle after the reset edge, PREADY=0, PRDATA=0, PSLVERR=0. The aborted write never lands.
- Wait counter range: a 4-bit counter; WAIT_CYCLES=15 completes at T16.

## Test plan
- Reset, then read word 3 (PADDR=0x0C) with WAIT_CYCLES=0 → PREADY=1 in T1, PRDATA=0x0000_0000, PSLVERR=0.
- Write 0xDEAD_BEEF to 0x04 with PSTRB=4'b1111, then read 0x04 → PRDATA=0xDEAD_BEEF.
- Write 0x1122_3344 to 0x08 with PSTRB=4'b0101 over a 0xFFFF_FFFF background, then read → PRDATA=0xFF22_FF44.
- WAIT_CYCLES=3, read 0x00:
  - PREADY=0 in T1–T3 and PREADY=1 in T4;
  - PRDATA=0 and PSLVERR=0 during T1–T3.
- Address errors:
  - write to 0x40 (index 16, MEM_DEPTH=16) → PSLVERR=1, memory unchanged;
  - read 0x06 (misaligned) → PSLVERR=1, PRDATA=0.
- Abort and reset:
  - PSEL dropped in T2 of a write with WAIT_CYCLES=2 → no PREADY, and a later read shows the old data;
  - PRESET asserted in the completion cycle of a write of 0xFFFF_FFFF → the later read returns 0.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB slave register memory with byte strobes, fixed wait states
// and PSLVERR on misaligned or out-of-range word accesses.
module apb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  take;
    logic                  active;
    logic                  err;
    logic                  wr_en;
    logic [IW-1:0]         widx;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         strb_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign active = PSEL & PENABLE;
    assign widx   = addr_q[IW+1:2];
    // Depth is a power of two, so any set bit above the index is out of range.
    assign err    = (|addr_q[1:0]) | (|addr_q[ADDR_WIDTH-1:IW+2]);
    assign wr_en  = PREADY & wr_q & ~err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        PREADY    = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    take      = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = SETUP;
                end
            end
            SETUP, ACCESS: begin
                if (!active) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    PREADY    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                    state_nxt = ACCESS;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (PREADY) begin
            PSLVERR = err;
            if (!wr_q && !err) PRDATA = mem[widx];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                addr_q  <= PADDR;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int w = 0; w < MEM_DEPTH; w++) mem[w] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem; four instances cover
// wait-state settings 0, 2, 3 and 15 on a shared bus.
module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] prdata [4];
    logic [3:0]  pready;
    logic [3:0]  pslverr;

    int checks   = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.WAIT_CYCLES(0)) u0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );
    apb_slave_mem #(.WAIT_CYCLES(2)) u2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );
    apb_slave_mem #(.WAIT_CYCLES(3)) u3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );
    apb_slave_mem #(.WAIT_CYCLES(15)) u15 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[3]),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[3]),
        .PREADY(pready[3]), .PSLVERR(pslverr[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle();
        psel    = 4'b0000;
        PENABLE = 1'b0;
    endtask

    function automatic int lat_of(input int u);
        case (u)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    // Full transfer; leaves the bus driven so the caller can chain
    // another setup in the very next cycle.
    task automatic xfer(input string tag, input int u, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic er);
        int n;
        psel    = 4'b0000;
        psel[u] = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        PSTRB   = s;
        rd      = 32'hxxxx_xxxx;
        er      = 1'bx;
        step();
        PENABLE = 1'b1;
        PADDR   = 32'h0000_0FF0;
        PWDATA  = 32'h5A5A_5A5A;
        PSTRB   = 4'b1111;
        PWRITE  = ~wr;
        n = 1;
        while (n <= 40) begin
            #3;
            if (pready[u]) begin
                rd = prdata[u];
                er = pslverr[u];
                break;
            end
            chk({tag, "_wait_rdata"}, prdata[u], 32'h0);
            chk({tag, "_wait_err"}, {31'b0, pslverr[u]}, 32'h0);
            step();
            n++;
        end
        chk({tag, "_latency"}, n, lat_of(u));
        step();
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        PRESET  = 1'b1;
        psel    = 4'b0000;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        step();
        step();
        PRESET = 1'b0;
        #3;
        chk("rst_ready", {28'b0, pready}, 32'h0);
        chk("rst_err", {28'b0, pslverr}, 32'h0);
        chk("rst_rdata", prdata[0], 32'h0);
        step();

        xfer("rd0c", 0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
        chk("rd0c_data", rd, 32'h0);
        chk("rd0c_err", {31'b0, er}, 32'h0);

        xfer("wr04", 0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, rd, er);
        chk("wr04_err", {31'b0, er}, 32'h0);
        xfer("rd04", 0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        chk("rd04_data", rd, 32'hDEAD_BEEF);

        xfer("wr08a", 0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd, er);
        xfer("wr08b", 0, 1'b1, 32'h08, 32'h1122_3344, 4'b0101, rd, er);
        xfer("rd08", 0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er);
        chk("rd08_data", rd, 32'hFF22_FF44);

        xfer("wr08z", 0, 1'b1, 32'h08, 32'h0, 4'b0000, rd, er);
        chk("wr08z_err", {31'b0, er}, 32'h0);
        xfer("rd08z", 0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er);
        chk("rd08z_data", rd, 32'hFF22_FF44);

        xfer("w3rd00", 2, 1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        chk("w3rd00_data", rd, 32'h0);
        chk("w3rd00_err", {31'b0, er}, 32'h0);

        xfer("wr40", 0, 1'b1, 32'h40, 32'hAAAA_AAAA, 4'hF, rd, er);
        chk("wr40_err", {31'b0, er}, 32'h1);
        xfer("rd00", 0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        chk("rd00_data", rd, 32'h0);
        chk("rd00_err", {31'b0, er}, 32'h0);
        xfer("rd06", 0, 1'b0, 32'h06, 32'h0, 4'h0, rd, er);
        chk("rd06_err", {31'b0, er}, 32'h1);
        chk("rd06_data", rd, 32'h0);
        xfer("wr05", 0, 1'b1, 32'h05, 32'h0, 4'hF, rd, er);
        chk("wr05_err", {31'b0, er}, 32'h1);
        xfer("rd04b", 0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        chk("rd04b_data", rd, 32'hDEAD_BEEF);
        idle();
        step();

        psel[0] = 1'b1;
        PENABLE = 1'b1;
        #3;
        chk("noset_ready0", {31'b0, pready[0]}, 32'h0);
        step();
        #3;
        chk("noset_ready1", {31'b0, pready[0]}, 32'h0);
        step();
        idle();

        xfer("w2wr10", 1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, rd, er);
        psel    = 4'b0010;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h10;
        PWDATA  = 32'h0BAD_F00D;
        PSTRB   = 4'hF;
        step();
        PENABLE = 1'b1;
        #3;
        chk("abort_t1_ready", {31'b0, pready[1]}, 32'h0);
        step();
        psel[1] = 1'b0;
        #3;
        chk("abort_t2_ready", {31'b0, pready[1]}, 32'h0);
        step();
        psel[1] = 1'b1;
        #3;
        chk("abort_t3_ready", {31'b0, pready[1]}, 32'h0);
        step();
        idle();
        step();
        xfer("w2rd10", 1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        chk("w2rd10_data", rd, 32'h1234_5678);

        psel    = 4'b0001;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h14;
        PWDATA  = 32'hFFFF_FFFF;
        PSTRB   = 4'hF;
        step();
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        #3;
        chk("rstcmp_ready", {31'b0, pready[0]}, 32'h1);
        step();
        PRESET = 1'b0;
        #3;
        chk("rstaft_ready", {31'b0, pready[0]}, 32'h0);
        chk("rstaft_rdata", prdata[0], 32'h0);
        chk("rstaft_err", {31'b0, pslverr[0]}, 32'h0);
        step();
        idle();
        step();
        xfer("rd14", 0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er);
        chk("rd14_data", rd, 32'h0);
        xfer("rd04c", 0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        chk("rd04c_data", rd, 32'h0);

        xfer("w15wr3c", 3, 1'b1, 32'h3C, 32'hCAFE_0123, 4'hF, rd, er);
        chk("w15wr3c_err", {31'b0, er}, 32'h0);
        xfer("w15rd3c", 3, 1'b0, 32'h3C, 32'h0, 4'h0, rd, er);
        chk("w15rd3c_data", rd, 32'hCAFE_0123);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
